// File: rtl/lemming_dig_arbiter.sv
// Single-shovel dig arbiter for four lemming FSMs.
// Round-robin grant, accept/timeout handshake, then a fixed two-cycle cooldown.
module lemming_dig_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] digging,
  output logic [3:0] dig,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] dig_count
);

  typedef enum logic [1:0] {StIdle, StGrant, StDig, StCool} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] timer_q, timer_d;
  logic [3:0] dig_q, dig_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       timeout_q, timeout_d;
  logic [7:0] count_q, count_d;

  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] idx;

  // Search starts at ptr and wraps, so no index has fixed priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    idx       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    dig_d     = dig_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          dig_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          timer_d  = 2'd0;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        if (digging[gnt_id_q]) begin
          dig_d   = 4'b0000;
          state_d = StDig;
        end else if (timer_q == 2'd2) begin
          dig_d     = 4'b0000;
          timeout_d = 1'b1;
          ptr_d     = gnt_id_q + 2'd1;
          timer_d   = 2'd0;
          state_d   = StCool;
        end else begin
          timer_d = timer_q + 2'd1;
        end
      end
      StDig: begin
        if (!digging[gnt_id_q]) begin
          if (count_q != 8'hff) count_d = count_q + 8'd1;
          ptr_d   = gnt_id_q + 2'd1;
          timer_d = 2'd0;
          state_d = StCool;
        end
      end
      StCool: begin
        // Timer reused to count the two cooldown cycles.
        if (timer_q == 2'd1) begin
          timer_d = 2'd0;
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      timer_q   <= 2'd0;
      dig_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      timeout_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      dig_q     <= dig_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign dig       = dig_q;
  assign gnt_id    = gnt_id_q;
  assign busy      = (state_q != StIdle);
  assign timeout   = timeout_q;
  assign dig_count = count_q;

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Directed self-checking bench for lemming_dig_arbiter.
module tb_lemming_dig_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] digging;
  logic [3:0] dig;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic [7:0] dig_count;

  int checks = 0;
  int errors = 0;

  lemming_dig_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .digging   (digging),
    .dig       (dig),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .dig_count (dig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; shovel must never be multi-hot.
  task automatic tick();
    @(posedge clk);
    #1;
    check_eq("dig_onehot0", 32'($onehot0(dig)), 32'd1);
  endtask

  task automatic do_reset();
    req     = 4'b0000;
    digging = 4'b0000;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_dig"}, 32'(dig), 32'd0);
    check_eq({tag, "_gnt"}, 32'(gnt_id), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_tmo"}, 32'(timeout), 32'd0);
    check_eq({tag, "_cnt"}, 32'(dig_count), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_id;
    rst     = 1'b0;
    req     = 4'b0000;
    digging = 4'b0000;
    #2 rst = 1'b1;
    #1;
    check_idle_zero("rst_init");
    do_reset();
    check_idle_zero("rst_done");

    // Single request for lemming 2
    req = 4'b0100;
    tick();
    check_eq("single_dig", 32'(dig), 32'b0100);
    check_eq("single_gnt", 32'(gnt_id), 32'd2);
    check_eq("single_busy", 32'(busy), 32'd1);
    digging = 4'b0100;
    tick();
    check_eq("accept_dig", 32'(dig), 32'd0);
    check_eq("accept_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check_eq("dig_hold_cnt", 32'(dig_count), 32'd0);
    digging = 4'b0000;
    req     = 4'b0000;
    tick();
    check_eq("single_cnt", 32'(dig_count), 32'd1);
    check_eq("cool1_busy", 32'(busy), 32'd1);
    tick();
    check_eq("cool2_busy", 32'(busy), 32'd1);
    tick();
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Round-robin with all requesting
    do_reset();
    req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      exp_id = 2'(g);
      check_eq("rr_gnt", 32'(gnt_id), 32'(exp_id));
      check_eq("rr_dig", 32'(dig), 32'(4'b0001 << exp_id));
      digging = 4'b0001 << exp_id;
      tick();
      digging = 4'b0000;
      tick();
      check_eq("rr_cool_dig", 32'(dig), 32'd0);
      check_eq("rr_cool_busy", 32'(busy), 32'd1);
      tick();
      check_eq("rr_cool2_busy", 32'(busy), 32'd1);
      tick();
      check_eq("rr_idle_busy", 32'(busy), 32'd0);
      check_eq("rr_idle_dig", 32'(dig), 32'd0);
      tick();
    end
    check_eq("rr_cnt", 32'(dig_count), 32'd5);

    // Timeout on lemming 1
    do_reset();
    req = 4'b0010;
    tick();
    check_eq("tmo_dig1", 32'(dig), 32'b0010);
    tick();
    check_eq("tmo_dig2", 32'(dig), 32'b0010);
    check_eq("tmo_early", 32'(timeout), 32'd0);
    tick();
    check_eq("tmo_dig3", 32'(dig), 32'b0010);
    tick();
    check_eq("tmo_dig_off", 32'(dig), 32'd0);
    check_eq("tmo_pulse", 32'(timeout), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd1);
    check_eq("tmo_cnt", 32'(dig_count), 32'd0);
    req = 4'b1111;
    tick();
    check_eq("tmo_pulse_end", 32'(timeout), 32'd0);
    tick();
    check_eq("tmo_idle", 32'(busy), 32'd0);
    tick();
    check_eq("tmo_ptr_gnt", 32'(gnt_id), 32'd2);
    check_eq("tmo_ptr_dig", 32'(dig), 32'b0100);

    // Ignored inputs during DIG for lemming 1
    do_reset();
    req = 4'b0010;
    tick();
    digging = 4'b0010;
    req     = 4'b0000;
    tick();
    digging = 4'b0011;
    req     = 4'b1000;
    tick();
    check_eq("ign_busy", 32'(busy), 32'd1);
    check_eq("ign_dig", 32'(dig), 32'd0);
    check_eq("ign_gnt", 32'(gnt_id), 32'd1);
    check_eq("ign_cnt", 32'(dig_count), 32'd0);
    digging = 4'b0010;
    req     = 4'b0000;
    tick();
    check_eq("ign_still_dig", 32'(dig_count), 32'd0);
    digging = 4'b0000;
    tick();
    check_eq("ign_done_cnt", 32'(dig_count), 32'd1);

    // Reset in the middle of DIG for lemming 3
    do_reset();
    req = 4'b1000;
    tick();
    check_eq("mid_gnt", 32'(gnt_id), 32'd3);
    digging = 4'b1000;
    tick();
    check_eq("mid_in_dig", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle_zero("mid_rst");
    @(negedge clk);
    rst     = 1'b0;
    digging = 4'b0000;
    req     = 4'b1001;
    @(posedge clk);
    #1;
    check_eq("post_rst_gnt", 32'(gnt_id), 32'd0);
    check_eq("post_rst_dig", 32'(dig), 32'b0001);
    check_eq("post_rst_cnt", 32'(dig_count), 32'd0);

    // Saturation after 256 completed digs
    do_reset();
    req = 4'b0001;
    tick();
    for (int i = 0; i < 256; i++) begin
      digging = 4'b0001;
      tick();
      digging = 4'b0000;
      tick();
      if (i == 253) check_eq("sat_254", 32'(dig_count), 32'd254);
      if (i == 254) check_eq("sat_255", 32'(dig_count), 32'd255);
      tick();
      tick();
      tick();
    end
    check_eq("sat_hold", 32'(dig_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
